spi_ram_arbiter: RTL and testbench

Two-port round-robin arbiter that shares the single `spi_ram_controller` between the CPU core (port 0) and a host/debug loader (port 1). Each requester holds a level read or write request. The arbiter latches the request, issues one start pulse to the controller, waits for the transaction to finish, and returns read data with a one-cycle done pulse. It sits between `cpu` and `spi_ram_controller`. The controller's SPI pins pass straight through and are not touched here.

---
 rtl/spi_ram_arb_pkg.sv | 29 ++
 rtl/spi_ram_arbiter_rr_pick2.sv | 26 ++
 rtl/spi_ram_arbiter.sv | 153 +++++++++++++++
 tb/tb_spi_ram_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ram_arb_pkg.sv
// -----------------------------------------------------------------------------
// spi_ram_arb_pkg
// Shared definitions for the two-port SPI RAM arbiter:
//   arb_state_t  - arbiter state machine encoding (also driven on dbg_state)
//   PORT_CPU / PORT_HOST - requester port indices
//   OP_READ / OP_WRITE   - latched operation encoding
//   port_onehot()        - port index to one-hot grant vector
// -----------------------------------------------------------------------------
package spi_ram_arb_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        SETTLE = 3'd2,
        WAIT   = 3'd3,
        DONE   = 3'd4
    } arb_state_t;

    localparam logic PORT_CPU  = 1'b0;
    localparam logic PORT_HOST = 1'b1;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    function automatic logic [1:0] port_onehot(input logic port);
        return (port == PORT_HOST) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/spi_ram_arbiter_rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
// Combinational two-way round-robin pick.
//   i_req  [1:0] request bits, bit n = port n
//   i_last       index of the port served most recently
//   o_win  [1:0] one-hot winner, 0 when nothing is requested
// On a tie the port that was not served last wins.
// -----------------------------------------------------------------------------
module rr_pick2
    import spi_ram_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_win
);

    always_comb begin
        o_win = 2'b00;
        if (i_req == 2'b11) begin
            o_win = (i_last == PORT_HOST) ? port_onehot(PORT_CPU) : port_onehot(PORT_HOST);
        end else begin
            o_win = i_req;
        end
    end

endmodule

// File: rtl/spi_ram_arbiter.sv
// -----------------------------------------------------------------------------
// spi_ram_arbiter
// Shares one spi_ram_controller between the CPU (port 0) and a host/debug
// loader (port 1). A level request is latched in IDLE, one start pulse is sent
// to the controller, the arbiter waits for busy to drop, then pulses the
// port's done for one cycle (read data already registered by then).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pN_addr/pN_wdata         request address / write data of port N
//   pN_read/pN_write         level requests (write wins over read)
//   pN_rdata/pN_done         registered read data / one-cycle completion
//   grant                    one-hot port being served, 0 when idle
//   mem_addr/mem_wdata       latched address/data to the controller
//   mem_start_read/_write    one-cycle start pulses to the controller
//   mem_rdata/mem_busy       controller read data and busy flag
//   dbg_state                current arbiter state (arb_state_t encoding)
// Handshake: a requester holds read/write high with stable addr/wdata until
// the edge that ends its done cycle; a request still high in the following
// IDLE cycle is a fresh transaction. Requests are only looked at in IDLE.
// -----------------------------------------------------------------------------
module spi_ram_arbiter
    import spi_ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH_BYTES = 2,
    parameter int ADDR_BITS        = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDR_BITS-1:0]          p0_addr,
    input  logic [ADDR_BITS-1:0]          p1_addr,
    input  logic [8*DATA_WIDTH_BYTES-1:0] p0_wdata,
    input  logic [8*DATA_WIDTH_BYTES-1:0] p1_wdata,
    input  logic                          p0_read,
    input  logic                          p1_read,
    input  logic                          p0_write,
    input  logic                          p1_write,
    output logic [8*DATA_WIDTH_BYTES-1:0] p0_rdata,
    output logic [8*DATA_WIDTH_BYTES-1:0] p1_rdata,
    output logic                          p0_done,
    output logic                          p1_done,
    output logic [1:0]                    grant,
    output logic [ADDR_BITS-1:0]          mem_addr,
    output logic [8*DATA_WIDTH_BYTES-1:0] mem_wdata,
    output logic                          mem_start_read,
    output logic                          mem_start_write,
    input  logic [8*DATA_WIDTH_BYTES-1:0] mem_rdata,
    input  logic                          mem_busy,
    output logic [2:0]                    dbg_state
);

    localparam int DW = 8 * DATA_WIDTH_BYTES;

    arb_state_t           r_state;
    arb_state_t           w_next;
    logic                 r_last;
    logic                 r_port;
    logic                 r_op;
    logic [ADDR_BITS-1:0] r_addr;
    logic [DW-1:0]        r_wdata;
    logic [DW-1:0]        r_p0_rdata;
    logic [DW-1:0]        r_p1_rdata;

    logic [1:0]           w_req;
    logic [1:0]           w_win;
    logic                 w_win_port;
    logic                 w_grant_now;
    logic                 w_finish;

    assign w_req = {p1_write | p1_read, p0_write | p0_read};

    rr_pick2 u_pick (
        .i_req  (w_req),
        .i_last (r_last),
        .o_win  (w_win)
    );

    assign w_win_port  = w_win[1];
    assign w_grant_now = (r_state == IDLE) && (w_req != 2'b00);
    assign w_finish    = (r_state == WAIT) && !mem_busy;

    // Next state and decoded outputs; everything outward-facing except the
    // data registers is a pure function of the current state.
    always_comb begin
        w_next          = r_state;
        grant           = 2'b00;
        mem_start_read  = 1'b0;
        mem_start_write = 1'b0;
        p0_done         = 1'b0;
        p1_done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req != 2'b00) w_next = ISSUE;
            end
            ISSUE: begin
                grant           = port_onehot(r_port);
                mem_start_read  = (r_op == OP_READ);
                mem_start_write = (r_op == OP_WRITE);
                w_next          = SETTLE;
            end
            // Dead cycle: the controller only raises busy after seeing start.
            SETTLE: begin
                grant  = port_onehot(r_port);
                w_next = WAIT;
            end
            WAIT: begin
                grant = port_onehot(r_port);
                if (!mem_busy) w_next = DONE;
            end
            DONE: begin
                grant   = port_onehot(r_port);
                p0_done = (r_port == PORT_CPU);
                p1_done = (r_port == PORT_HOST);
                w_next  = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_last     <= PORT_HOST;
            r_port     <= PORT_CPU;
            r_op       <= OP_READ;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_p0_rdata <= '0;
            r_p1_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_grant_now) begin
                r_port  <= w_win_port;
                r_addr  <= w_win_port ? p1_addr  : p0_addr;
                r_wdata <= w_win_port ? p1_wdata : p0_wdata;
                r_op    <= (w_win_port ? p1_write : p0_write) ? OP_WRITE : OP_READ;
            end
            if (w_finish) begin
                r_last <= r_port;
                if (r_op == OP_READ) begin
                    if (r_port == PORT_HOST) r_p1_rdata <= mem_rdata;
                    else                     r_p0_rdata <= mem_rdata;
                end
            end
        end
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign p0_rdata  = r_p0_rdata;
    assign p1_rdata  = r_p1_rdata;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spi_ram_arbiter
// Directed bench: a small controller model answers start pulses, a
// transaction-level model predicts every output each cycle, and the directed
// sequences pin the model with literal expectations.
// -----------------------------------------------------------------------------
module tb_spi_ram_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] p0_addr = '0, p1_addr = '0;
  logic [15:0] p0_wdata = '0, p1_wdata = '0;
  logic        p0_read = 0, p1_read = 0, p0_write = 0, p1_write = 0;
  logic [15:0] p0_rdata, p1_rdata;
  logic        p0_done, p1_done;
  logic [1:0]  grant;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_start_read, mem_start_write;
  logic [15:0] mem_rdata;
  logic        mem_busy;
  logic [2:0]  dbg_state;

  spi_ram_arbiter #(.DATA_WIDTH_BYTES(2), .ADDR_BITS(16)) dut (
    .clk(clk), .rst(rst),
    .p0_addr(p0_addr), .p1_addr(p1_addr),
    .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
    .p0_read(p0_read), .p1_read(p1_read),
    .p0_write(p0_write), .p1_write(p1_write),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .p0_done(p0_done), .p1_done(p1_done),
    .grant(grant),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_start_read(mem_start_read), .mem_start_write(mem_start_write),
    .mem_rdata(mem_rdata), .mem_busy(mem_busy),
    .dbg_state(dbg_state)
  );

  // ---------------- controller model ----------------
  logic [15:0] mem [0:255];
  int          busy_len = 0;
  int          busy_cnt;
  logic        load_we = 0;
  logic [7:0]  load_a = '0;
  logic [15:0] load_d = '0;

  always @(posedge clk) begin
    if (load_we) mem[load_a] <= load_d;
    if (rst) begin
      busy_cnt  <= 0;
      mem_rdata <= '0;
    end else if (mem_start_read || mem_start_write) begin
      busy_cnt <= busy_len;
      if (mem_start_write) mem[mem_addr[7:0]] <= mem_wdata;
      else                 mem_rdata <= mem[mem_addr[7:0]];
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end
  assign mem_busy = (busy_cnt != 0);

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- event monitor ----------------
  int          mcyc = 0;
  int          n_srd = 0, n_swr = 0, n_d0 = 0, n_d1 = 0;
  logic [1:0]  g_q[$];
  int          s_q[$];
  logic [15:0] st_addr, st_wdata;

  always @(negedge clk) begin
    mcyc++;
    if (mem_start_read)  n_srd++;
    if (mem_start_write) n_swr++;
    if (p0_done) n_d0++;
    if (p1_done) n_d1++;
    if (mem_start_read || mem_start_write) begin
      g_q.push_back(grant);
      s_q.push_back(mcyc);
      st_addr  = mem_addr;
      st_wdata = mem_wdata;
    end
  end

  // ---------------- transaction-level reference model ----------------
  // One transaction at a time: issued the cycle after it is picked, done the
  // cycle after busy is first seen low at least two cycles after issue.
  int          cyc = 0;
  bit          m_on = 0, m_act = 0;
  logic        m_port, m_op, m_last, m_sel, m_r0, m_r1;
  int          m_issue, m_done;
  logic [15:0] m_addr, m_wdata;
  logic [15:0] m_rd [2];
  logic [1:0]  e_grant;

  always @(negedge clk) begin
    if (m_on) begin
      e_grant = m_act ? (m_port ? 2'b10 : 2'b01) : 2'b00;
      chk("grant", grant, e_grant);
      chk("start_read",  mem_start_read,  m_act && cyc == m_issue && !m_op);
      chk("start_write", mem_start_write, m_act && cyc == m_issue && m_op);
      chk("p0_done", p0_done, m_act && cyc == m_done && !m_port);
      chk("p1_done", p1_done, m_act && cyc == m_done && m_port);
      chk("mem_addr",  mem_addr,  m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("p0_rdata",  p0_rdata,  m_rd[0]);
      chk("p1_rdata",  p1_rdata,  m_rd[1]);
    end
    if (rst) begin
      m_on = 1; m_act = 0; m_last = 1'b1;
      m_addr = '0; m_wdata = '0; m_rd[0] = '0; m_rd[1] = '0;
    end else if (m_on) begin
      if (!m_act) begin
        m_r0 = p0_read | p0_write;
        m_r1 = p1_read | p1_write;
        if (m_r0 || m_r1) begin
          m_sel   = (m_r0 && m_r1) ? ~m_last : m_r1;
          m_port  = m_sel;
          m_addr  = m_sel ? p1_addr  : p0_addr;
          m_wdata = m_sel ? p1_wdata : p0_wdata;
          m_op    = m_sel ? p1_write : p0_write;
          m_act   = 1;
          m_issue = cyc + 1;
          m_done  = -1;
        end
      end else if (m_done == cyc) begin
        m_act = 0;
      end else if (m_done < 0 && cyc >= m_issue + 2 && !mem_busy) begin
        if (!m_op) m_rd[m_port] = mem_rdata;
        m_last = m_port;
        m_done = cyc + 1;
      end
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    load_a = a; load_d = d; load_we = 1;
    step();
    load_we = 0;
  endtask

  // Returns just after the edge that ends the port's done cycle.
  task automatic wait_done(input int p);
    bit seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if ((p == 0 && p0_done) || (p == 1 && p1_done)) seen = 1;
    end
    chk("done_seen", seen, 1);
    @(posedge clk); #1;
  endtask

  task automatic clear_counts();
    n_srd = 0; n_swr = 0; n_d0 = 0; n_d1 = 0;
    g_q.delete(); s_q.delete();
  endtask

  // ---------------- directed sequences ----------------
  initial begin
    int dones;
    rst = 1;
    step();
    preload(8'h10, 16'h1234);
    preload(8'h40, 16'hAAAA);
    preload(8'h41, 16'h5555);
    preload(8'h20, 16'h2020);
    preload(8'h30, 16'h3030);
    @(negedge clk);
    chk("rst_grant", grant, 2'b00);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_p0_rdata", p0_rdata, 16'h0000);
    chk("rst_dbg_state", dbg_state, 3'd0);
    @(posedge clk); #1;
    rst = 0;

    // Single read, busy 40 cycles
    busy_len = 40;
    clear_counts();
    p0_addr = 16'h0010; p0_read = 1;
    wait_done(0);
    p0_read = 0;
    repeat (3) step();
    chk("single_srd", n_srd, 1);
    chk("single_swr", n_swr, 0);
    chk("single_addr", st_addr, 16'h0010);
    chk("single_rdata", p0_rdata, 16'h1234);
    chk("single_d0", n_d0, 1);
    chk("single_d1", n_d1, 0);

    // Contention right after reset: grants 01,10,01,10
    rst = 1;
    step();
    busy_len = 3;
    clear_counts();
    rst = 0;
    p0_addr = 16'h0040; p1_addr = 16'h0041;
    p0_read = 1; p1_read = 1;
    dones = 0;
    for (int i = 0; i < 400 && dones < 4; i++) begin
      @(negedge clk);
      if (p0_done || p1_done) dones++;
    end
    @(posedge clk); #1;
    p0_read = 0; p1_read = 0;
    repeat (4) step();
    chk("cont_count", g_q.size(), 4);
    if (g_q.size() == 4) begin
      chk("cont_g0", g_q[0], 2'b01);
      chk("cont_g1", g_q[1], 2'b10);
      chk("cont_g2", g_q[2], 2'b01);
      chk("cont_g3", g_q[3], 2'b10);
    end
    chk("cont_p0_rdata", p0_rdata, 16'hAAAA);
    chk("cont_p1_rdata", p1_rdata, 16'h5555);

    // Read and write both high on port 1: write wins
    clear_counts();
    p1_addr = 16'h00FF; p1_wdata = 16'hBEEF; p1_read = 1; p1_write = 1;
    wait_done(1);
    p1_read = 0; p1_write = 0;
    chk("rw_swr", n_swr, 1);
    chk("rw_srd", n_srd, 0);
    chk("rw_wdata", st_wdata, 16'hBEEF);
    p0_addr = 16'h00FF; p0_read = 1;
    wait_done(0);
    p0_read = 0;
    chk("rw_readback", p0_rdata, 16'hBEEF);
    chk("rw_p1_keep", p1_rdata, 16'h5555);

    // Address change mid-transaction
    busy_len = 10;
    clear_counts();
    p0_addr = 16'h0020; p0_read = 1;
    repeat (3) step();
    p0_addr = 16'h0030;
    wait_done(0);
    p0_read = 0;
    repeat (3) step();
    chk("mid_srd", n_srd, 1);
    chk("mid_addr", mem_addr, 16'h0020);
    chk("mid_rdata", p0_rdata, 16'h2020);

    // Reset while waiting on busy
    busy_len = 40;
    p0_addr = 16'h0010; p0_read = 1;
    repeat (5) step();
    clear_counts();
    rst = 1; p0_read = 0;
    step();
    rst = 0;
    @(negedge clk);
    chk("rmid_grant", grant, 2'b00);
    chk("rmid_p0_rdata", p0_rdata, 16'h0000);
    repeat (4) step();
    chk("rmid_nodone", n_d0, 0);
    busy_len = 2;
    p0_read = 1;
    wait_done(0);
    p0_read = 0;
    chk("rmid_after", p0_rdata, 16'h1234);

    // Back-to-back on port 0 with zero busy
    busy_len = 0;
    step();
    clear_counts();
    p0_addr = 16'h0040; p0_read = 1;
    dones = 0;
    for (int i = 0; i < 100 && dones < 2; i++) begin
      @(negedge clk);
      if (p0_done) dones++;
    end
    @(posedge clk); #1;
    p0_read = 0;
    repeat (3) step();
    chk("b2b_count", s_q.size(), 2);
    if (s_q.size() == 2) chk("b2b_spacing", s_q[1] - s_q[0], 5);

    repeat (2) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
